baud_rate_gen_master: RTL

BAUD_RATE_GEN_MASTER -- requirements
Module: baud_rate_gen_master

---
 rtl/baud_rate_gen_master_if.sv | 26 ++
 rtl/baud_rate_gen_master.sv | 102 ++++++++++
 2 files changed

// File: rtl/baud_rate_gen_master_if.sv
// Control/status bundle between the SPI master control logic and the baud-rate generator.
// The master modport is the generator's view; slave is the controller's view.
interface baud_rate_gen_master_if #(
    parameter int DATA_WIDTH = 8,
    parameter int SPR_W      = 3
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic             SPE;
    logic [SPR_W-1:0] SPR;
    logic             start;
    logic             M_BaudRate;
    logic             idle;
    logic [CNT_W-1:0] bit_cnt;
    logic             done;

    modport master (
        input  SPE, SPR, start,
        output M_BaudRate, idle, bit_cnt, done
    );

    modport slave (
        output SPE, SPR, start,
        input  M_BaudRate, idle, bit_cnt, done
    );
endinterface

// File: rtl/baud_rate_gen_master.sv
// SPI master baud-rate generator: divides clk by 2*2^SPR into M_BaudRate for one
// DATA_WIDTH-bit transfer per start request, counting completed bits on falling toggles.
module baud_rate_gen_master #(
    parameter int DATA_WIDTH = 8,
    parameter int SPR_W      = 3
) (
    input  logic                      clk,
    input  logic                      rst_n,
    baud_rate_gen_master_if.master    bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    // Wide enough to hold H-1 for the largest selectable H = 2^(2^SPR_W - 1).
    localparam int DIV_W = (((1 << SPR_W) - 1) > 0) ? ((1 << SPR_W) - 1) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [SPR_W-1:0] spr_q,   spr_d;
    logic [DIV_W-1:0] div_q,   div_d;
    logic             baud_q,  baud_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             done_q,  done_d;

    logic [DIV_W-1:0] div_max;
    logic             cnt_last;

    assign div_max  = DIV_W'((64'd1 << spr_q) - 64'd1);
    assign cnt_last = (cnt_q == CNT_W'(DATA_WIDTH - 1));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        spr_d   = spr_q;
        div_d   = div_q;
        baud_d  = baud_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                div_d  = '0;
                baud_d = 1'b0;
                cnt_d  = '0;
                if (bus.SPE && bus.start) begin
                    state_d = ST_RUN;
                    spr_d   = bus.SPR;
                end
            end
            ST_RUN: begin
                if (!bus.SPE) begin
                    // Abort: silent return to idle, no completion pulse.
                    state_d = ST_IDLE;
                    div_d   = '0;
                    baud_d  = 1'b0;
                    cnt_d   = '0;
                end else if (div_q == div_max) begin
                    div_d  = '0;
                    baud_d = ~baud_q;
                    if (baud_q) begin
                        // Falling toggle closes a bit; the last one ends the transfer.
                        if (cnt_last) begin
                            state_d = ST_IDLE;
                            baud_d  = 1'b0;
                            cnt_d   = '0;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            spr_q   <= '0;
            div_q   <= '0;
            baud_q  <= 1'b0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            spr_q   <= spr_d;
            div_q   <= div_d;
            baud_q  <= baud_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.M_BaudRate = baud_q;
    assign bus.idle       = (state_q == ST_IDLE);
    assign bus.bit_cnt    = cnt_q;
    assign bus.done       = done_q;
endmodule
